multiply_n_bit_seq: RTL and testbench

Parametrised sequential shift-add multiplier, the successor to the 4-bit start/stop multiplier. It multiplies two N-bit operands over N clock cycles and supports unsigned and two's-complement signed modes, selected per operation. Uses the same start/stop handshake so the existing file-driven multiplier bench drives it unchanged at N=4 in unsigned mode. Sits in the arithmetic datapath wherever a small-area, multi-cycle multiply is acceptable.

---
 rtl/multiply_n_bit_seq.sv | 94 +++++++++
 tb/tb_multiply_n_bit_seq.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/multiply_n_bit_seq.sv
// Sequential shift-add multiplier: N-bit operands, 2N-bit product, one iteration per clock.
// Unsigned or two's-complement signed per operation, with a start/stop handshake.
module multiply_n_bit_seq #(
  parameter int N = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [N-1:0]     X,
  input  logic [N-1:0]     Y,
  output logic             busy,
  output logic             stop,
  output logic [2*N-1:0]   P
);

  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t          state;
  logic [2*N:0]    acc;
  logic [N-1:0]    mcand;
  logic [N-1:0]    mplier;
  logic            neg;
  logic [CW-1:0]   cnt;

  logic [N:0]      upper_sum;
  logic [2*N:0]    acc_next;

  // |v| as an N-bit unsigned value; the most negative input maps onto 2^(N-1) exactly.
  function automatic logic [N-1:0] magnitude(input logic [N-1:0] v, input logic sgn);
    return (sgn && v[N-1]) ? -v : v;
  endfunction

  function automatic logic [2*N-1:0] apply_sign(input logic [2*N-1:0] v, input logic n);
    return n ? -v : v;
  endfunction

  // acc[2N] is always zero before the add, so the N+1-bit sum cannot overflow.
  always_comb begin
    upper_sum = acc[2*N:N] + (mplier[0] ? {1'b0, mcand} : '0);
    acc_next  = {1'b0, upper_sum, acc[N-1:1]};
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      busy   <= 1'b0;
      stop   <= 1'b0;
      P      <= '0;
      cnt    <= '0;
      acc    <= '0;
      mcand  <= '0;
      mplier <= '0;
      neg    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          stop <= 1'b0;
          if (start) begin
            mcand  <= magnitude(X, signed_mode);
            mplier <= magnitude(Y, signed_mode);
            neg    <= signed_mode & (X[N-1] ^ Y[N-1]);
            acc    <= '0;
            cnt    <= '0;
            state  <= RUN;
            busy   <= 1'b1;
          end else begin
            state  <= IDLE;
            busy   <= 1'b0;
          end
        end
        RUN: begin
          acc    <= acc_next;
          mplier <= mplier >> 1;
          cnt    <= cnt + CW'(1);
          if (cnt == CW'(N - 1)) begin
            P     <= apply_sign(acc_next[2*N-1:0], neg);
            state <= DONE;
            busy  <= 1'b0;
            stop  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          stop  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multiply_n_bit_seq.sv
// Scoreboard bench for multiply_n_bit_seq: one N=4 and one N=8 instance on a shared clock and reset.
module tb_multiply_n_bit_seq;

  logic        clk = 1'b0;
  logic        rst;
  logic        start4, sm4, busy4, stop4;
  logic [3:0]  x4, y4;
  logic [7:0]  p4;
  logic        start8, sm8, busy8, stop8;
  logic [7:0]  x8, y8;
  logic [15:0] p8;

  int total = 0;
  int bad   = 0;
  int stop_cnt4 = 0;
  int stop_cnt8 = 0;
  logic [15:0] sb4[$];
  logic [15:0] sb8[$];

  always #5 clk = ~clk;

  multiply_n_bit_seq #(.N(4)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .signed_mode(sm4),
    .X(x4), .Y(y4), .busy(busy4), .stop(stop4), .P(p4)
  );

  multiply_n_bit_seq #(.N(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8),
    .X(x8), .Y(y8), .busy(busy8), .stop(stop8), .P(p8)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // Completion monitor: every stop pulse pops one expected product.
  always @(negedge clk) begin
    if (stop4) begin
      stop_cnt4++;
      chk("stop_busy4", {31'b0, busy4}, 32'd0);
      if (sb4.size() == 0) chk("unexpected_stop4", 32'd1, 32'd0);
      else chk("P4", {24'b0, p4}, {16'b0, sb4.pop_front()});
    end
    if (stop8) begin
      stop_cnt8++;
      chk("stop_busy8", {31'b0, busy8}, 32'd0);
      if (sb8.size() == 0) chk("unexpected_stop8", 32'd1, 32'd0);
      else chk("P8", {16'b0, p8}, {16'b0, sb8.pop_front()});
    end
  end

  // Called just after an edge; returns the number of further edges until stop rises.
  task automatic wait_stop(input bit w, output int c);
    c = 0;
    while (c < 30) begin
      if (w ? stop8 : stop4) break;
      chk(w ? "busy8" : "busy4", {31'b0, (w ? busy8 : busy4)}, 32'd1);
      @(posedge clk); #1;
      c++;
    end
  endtask

  task automatic launch(input bit w, input logic [7:0] x, input logic [7:0] y,
                        input logic sm, input logic [15:0] exp);
    @(negedge clk);
    if (w) begin
      x8 = x; y8 = y; sm8 = sm; start8 = 1'b1; sb8.push_back(exp);
    end else begin
      x4 = x[3:0]; y4 = y[3:0]; sm4 = sm; start4 = 1'b1; sb4.push_back(exp);
    end
    @(posedge clk); #1;
    start4 = 1'b0;
    start8 = 1'b0;
  endtask

  task automatic run_op(input bit w, input logic [7:0] x, input logic [7:0] y,
                        input logic sm, input logic [15:0] exp);
    int c;
    launch(w, x, y, sm, exp);
    wait_stop(w, c);
    chk(w ? "latency8" : "latency4", c, w ? 32'd8 : 32'd4);
    @(posedge clk); #1;
    chk(w ? "stop_fall8" : "stop_fall4", {31'b0, (w ? stop8 : stop4)}, 32'd0);
  endtask

  initial begin
    int c;
    int sc;
    rst = 1'b1;
    start4 = 1'b0; sm4 = 1'b0; x4 = '0; y4 = '0;
    start8 = 1'b0; sm8 = 1'b0; x8 = '0; y8 = '0;
    #12;
    chk("rst_busy", {31'b0, busy4}, 32'd0);
    chk("rst_stop", {31'b0, stop4}, 32'd0);
    chk("rst_P",    {24'b0, p4},    32'd0);
    @(negedge clk);
    rst = 1'b0;

    // unsigned 15*15, then P must hold
    run_op(1'b0, 8'd15, 8'd15, 1'b0, 16'd225);
    repeat (10) @(posedge clk);
    #1 chk("P_hold", {24'b0, p4}, 32'd225);

    // signed cases
    run_op(1'b0, 8'h08, 8'h08, 1'b1, 16'h40);
    run_op(1'b0, 8'h0D, 8'h05, 1'b1, 16'hF1);
    run_op(1'b0, 8'h07, 8'h00, 1'b1, 16'h00);
    run_op(1'b0, 8'h0B, 8'h07, 1'b0, 16'd77);

    // start during RUN must be ignored
    sc = stop_cnt4;
    launch(1'b0, 8'd6, 8'd7, 1'b0, 16'd42);
    @(posedge clk); #1;
    start4 = 1'b1; x4 = 4'd1; y4 = 4'd1;
    @(posedge clk); #1;
    start4 = 1'b0;
    wait_stop(1'b0, c);
    chk("ignore_latency", c, 32'd2);
    repeat (8) @(posedge clk);
    #1 chk("ignore_stops", stop_cnt4 - sc, 32'd1);

    // back-to-back with start held high
    @(negedge clk);
    x4 = 4'd3; y4 = 4'd5; sm4 = 1'b0; start4 = 1'b1; sb4.push_back(16'd15);
    @(posedge clk); #1;
    wait_stop(1'b0, c);
    chk("b2b_lat1", c, 32'd4);
    x4 = 4'd9; y4 = 4'd9; sb4.push_back(16'd81);
    @(posedge clk); #1;
    start4 = 1'b0;
    chk("b2b_busy", {31'b0, busy4}, 32'd1);
    chk("b2b_stop_low", {31'b0, stop4}, 32'd0);
    c = 1;
    while (!stop4 && c < 30) begin
      @(posedge clk); #1;
      c++;
    end
    chk("b2b_gap", c, 32'd5);
    repeat (3) @(posedge clk);

    // asynchronous reset in the middle of RUN
    sc = stop_cnt4;
    @(negedge clk);
    x4 = 4'd13; y4 = 4'd11; start4 = 1'b1;
    @(posedge clk); #1;
    start4 = 1'b0;
    @(posedge clk);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    chk("arst_P",    {24'b0, p4},    32'd0);
    chk("arst_busy", {31'b0, busy4}, 32'd0);
    chk("arst_stop", {31'b0, stop4}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (8) @(posedge clk);
    #1 chk("arst_no_stop", stop_cnt4 - sc, 32'd0);
    run_op(1'b0, 8'd2, 8'd3, 1'b0, 16'd6);

    // N=8 instance
    run_op(1'b1, 8'd255, 8'd255, 1'b0, 16'd65025);
    run_op(1'b1, 8'h80, 8'd127, 1'b1, 16'hC080);
    run_op(1'b1, 8'h80, 8'h80, 1'b1, 16'h4000);

    repeat (3) @(posedge clk);
    chk("sb4_empty", sb4.size(), 32'd0);
    chk("sb8_empty", sb8.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
